ram_master_ctrl: RTL
====================

Name: ram_master_ctrl

Overview:
- Initiator-side controller driving the SoC's 256x32 word RAM (CE/RD/WR, 8-bit word address, combinational read data, write on clock edge).
- Accepts byte-addressed load/store requests from the core LSU via a valid/ready handshake.
- Performs sub-word stores by read-modify-write, and sign/zero extension for loads.
- Returns one response per request on a valid/ready response channel.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0.
- ADDR_W, 8, RAM word-address width; window size = 4*2^ADDR_W bytes.

Ports:
- iRMC_CLK  in  1  clock
- iRMC_RST  in  1  synchronous, active-high reset
- iREQ_VALID  in  1  request valid
- oREQ_READY  out  1  high only in IDLE
- iREQ_WE  in  1  1=store, 0=load
- iREQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- iREQ_UNSIGNED  in  1  zero-extend load
- iREQ_ADDR  in  32  byte address
- iREQ_WDATA  in  32  store data, right-aligned
- oRSP_VALID  out  1  response valid
- iRSP_READY  in  1  response accepted
- oRSP_RDATA  out  32  extended load data; 0 for stores/errors
- oRSP_ERR  out  1  misaligned, out-of-window or illegal size
- oRAM_CE  out  1  RAM chip enable
- oRAM_RD  out  1  RAM read strobe
- oRAM_WR  out  1  RAM write strobe
- oRAM_ADDR  out  ADDR_W  RAM word address
- oRAM_DATA  out  32  write data to RAM
- iRAM_DATA  in  32  read data from RAM (valid same cycle as CE&RD)

Behaviour:
- Reset: state=IDLE; oREQ_READY=1; oRSP_VALID=0; oRSP_RDATA=0; oRSP_ERR=0; all oRAM_* = 0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: on iREQ_VALID&oREQ_READY, latch the request and the decoded word offset off = iREQ_ADDR-BASE_ADDR.
  - Error detected -> RESP with ERR=1; no RAM access.
  - Load, or sub-word store -> READ.
  - Word store -> WRITE.
- READ: one cycle with CE=RD=1, ADDR=off[ADDR_W+1:2]; iRAM_DATA captured at cycle end.
  - Load -> RESP.
  - Sub-word store -> WRITE.
- WRITE: one cycle with CE=WR=1, ADDR held.
  - Data: word = WDATA.
  - Byte: captured word with lane addr[1:0] replaced by WDATA[7:0].
  - Half: lane addr[1] replaced by WDATA[15:0].
  - Next state -> RESP.
- RESP: oRSP_VALID=1; RDATA/ERR stable until iRSP_READY; then -> IDLE.
- Load extraction: select lane by addr[1:0] (byte) or addr[1] (half). Sign-extend unless UNSIGNED; word loads ignore UNSIGNED.
- Latency from accept cycle T:
  - Load: READ at T+1, RSP_VALID at T+2.
  - Word store: WRITE at T+1, RSP_VALID at T+2.
  - Sub-word store: READ T+1, WRITE T+2, RSP_VALID T+3.
  - Error: RSP_VALID T+1.
- Throughput: one request outstanding. Earliest next accept is the cycle after the RSP handshake.
- RAM strobes are decoded from state and gated with ~iRMC_RST. A reset asserted in a WRITE cycle suppresses that write, and the RAM is unmodified.
- Reset mid-operation: the request is abandoned with no response.
- oRAM_CE/RD/WR are 0 in IDLE and RESP. oRAM_ADDR/oRAM_DATA hold their last values (don't-care when CE=0).
- Window check (under macro): valid iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_W, computed in 33 bits so addr wrap near 32'hFFFF_FFFF never passes.

Optional Feature:
- Macro: RMC_ERR_CHECK_EN.
- Defined:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0), out-of-window, or SIZE=11 -> ERR=1, RDATA=0, no RAM access.
- Undefined:
  - oRSP_ERR tied 0; no checks.
  - Word index = off[ADDR_W+1:2], truncated (wraps modulo window).
  - Misaligned half/word are force-aligned by ignoring the offending low bits.
  - SIZE=11 treated as word.

Test Plan:
- Word store 32'hDEADBEEF @BASE+0x10, then word load @BASE+0x10 -> ADDR=0x04; RSP_VALID 2 cycles after accept; RDATA=32'hDEADBEEF; ERR=0.
- RAM word 5 = 32'h11223344; byte store 8'hAA @BASE+0x16 -> READ then WRITE cycle, word 5 = 32'h11AA3344; RSP_VALID at T+3.
- Byte load @BASE+0x17 of 32'h80FF0000, UNSIGNED=0 -> 32'hFFFFFF80; UNSIGNED=1 -> 32'h00000080. Half load @BASE+0x16 signed -> 32'hFFFF80FF.
- iRSP_READY held low 4 cycles -> RSP_VALID/RDATA stable, oREQ_READY=0, no RAM strobes; release -> IDLE next cycle.
- With RMC_ERR_CHECK_EN:
  - Word load @BASE+0x2 -> ERR=1, RDATA=0, RSP_VALID at T+1, CE never asserted.
  - Load @BASE+0x400 -> ERR=1.
  - Without the macro, the same load @BASE+0x400 reads word 0.
- Assert iRMC_RST during the WRITE cycle of a sub-word store -> oRAM_WR=0 that cycle; RAM word unchanged; outputs at reset values; no response issued.

Source files
------------

// File: rtl/ram_master_ctrl.sv
// LSU-to-RAM master: byte-addressed load/store requests onto a 256x32 word RAM port,
// with read-modify-write for sub-word stores. Optional error checks under RMC_ERR_CHECK_EN.
module ram_master_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              iRMC_CLK,
    input  logic              iRMC_RST,
    input  logic              iREQ_VALID,
    output logic              oREQ_READY,
    input  logic              iREQ_WE,
    input  logic [1:0]        iREQ_SIZE,
    input  logic              iREQ_UNSIGNED,
    input  logic [31:0]       iREQ_ADDR,
    input  logic [31:0]       iREQ_WDATA,
    output logic              oRSP_VALID,
    input  logic              iRSP_READY,
    output logic [31:0]       oRSP_RDATA,
    output logic              oRSP_ERR,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [31:0]       oRAM_DATA,
    input  logic [31:0]       iRAM_DATA
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_data_q, ram_data_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0] off;
    logic [1:0]  req_size;
    logic        req_err;
    logic        unused_off;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (sz)
            SzByte:  r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SzHalf:  r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = w;
        case (sz)
            SzByte:  r[{lane, 3'b000} +: 8] = wd[7:0];
            SzHalf:  r[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign off        = iREQ_ADDR - BASE_ADDR;
    assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
    // Illegal size 11 behaves as a word access when checks are disabled.
    assign req_size   = (iREQ_SIZE == 2'b11) ? SzWord : iREQ_SIZE;

`ifdef RMC_ERR_CHECK_EN
    logic [32:0] addr_ext, base_ext, limit_ext;
    logic        in_win, misaligned;

    // 33-bit compare so an address near the top of memory cannot wrap into the window.
    assign addr_ext   = {1'b0, iREQ_ADDR};
    assign base_ext   = {1'b0, BASE_ADDR};
    assign limit_ext  = base_ext + (33'd4 << ADDR_W);
    assign in_win     = (addr_ext >= base_ext) && (addr_ext < limit_ext);
    assign misaligned = ((iREQ_SIZE == SzHalf) && iREQ_ADDR[0]) ||
                        ((iREQ_SIZE == SzWord) && (iREQ_ADDR[1:0] != 2'b00));
    assign req_err    = !in_win || misaligned || (iREQ_SIZE == 2'b11);
`else
    assign req_err    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (iREQ_VALID) begin
                    we_d        = iREQ_WE;
                    size_d      = req_size;
                    uns_d       = iREQ_UNSIGNED;
                    lane_d      = iREQ_ADDR[1:0];
                    rsp_rdata_d = 32'd0;
                    if (req_err) begin
                        rsp_err_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        rsp_err_d  = 1'b0;
                        ram_addr_d = off[ADDR_W+1:2];
                        ram_data_d = iREQ_WDATA;
                        state_d    = (!iREQ_WE || req_size != SzWord) ? StRead : StWrite;
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    // ram_data_q still holds the right-aligned store data here.
                    ram_data_d = store_merge(iRAM_DATA, ram_data_q, size_q, lane_q);
                    state_d    = StWrite;
                end else begin
                    rsp_rdata_d = load_extract(iRAM_DATA, size_q, lane_q, uns_q);
                    state_d     = StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (iRSP_READY) begin
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iRMC_CLK) begin
        if (iRMC_RST) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= SzByte;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            ram_addr_q  <= '0;
            ram_data_q  <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign oREQ_READY = (state_q == StIdle);
    assign oRSP_VALID = (state_q == StResp);
    assign oRSP_RDATA = rsp_rdata_q;
    assign oRSP_ERR   = rsp_err_q;
    // Strobes are gated by reset so a reset landing in a WRITE cycle cannot corrupt the RAM.
    assign oRAM_RD    = (state_q == StRead) & ~iRMC_RST;
    assign oRAM_WR    = (state_q == StWrite) & ~iRMC_RST;
    assign oRAM_CE    = oRAM_RD | oRAM_WR;
    assign oRAM_ADDR  = ram_addr_q;
    assign oRAM_DATA  = ram_data_q;

endmodule
